// File: rtl/card_pkg.sv
// Shared card/slot constants, draw FSM states and slot helpers for the deck blocks.
package card_pkg;

    localparam logic [5:0]  CARD_EMPTY = 6'd54;
    localparam int unsigned NUM_SLOTS  = 106;
    localparam int unsigned NUM_KINDS  = 54;
    localparam int unsigned IDX_W      = 7;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_e;

    // Slots 54..105 hold the second copies of cards 0..51.
    function automatic logic [5:0] slot_to_card(input logic [IDX_W-1:0] slot);
        logic [IDX_W-1:0] c;
        c = (slot < IDX_W'(NUM_KINDS)) ? slot : slot - IDX_W'(NUM_KINDS);
        return c[5:0];
    endfunction

    // Fold the low 7 LFSR bits into the slot range 0..105.
    function automatic logic [IDX_W-1:0] start_index(input logic [15:0] lfsr);
        logic [IDX_W-1:0] s;
        s = lfsr[IDX_W-1:0];
        return (s >= IDX_W'(NUM_SLOTS)) ? s - IDX_W'(NUM_SLOTS) : s;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; a zero seed is replaced by 1 to avoid lock-up.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] state
);

    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Taps 15,13,12,10 shifted in at the bottom.
    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    // State register, advancing every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr_q <= SEED_EFF;
        else     lfsr_q <= lfsr_d;
    end

    assign state = lfsr_q;

endmodule

// File: rtl/deck_draw_picker.sv
// Draws one undrawn slot by scanning a snapshot of the slot map from an LFSR-derived start.
module deck_draw_picker
    import card_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 interboard_rst,
    input  logic                 req,
    input  logic [NUM_SLOTS-1:0] available_card,
    output logic                 busy,
    output logic                 done,
    output logic [5:0]           card,
    output logic                 empty
);

    logic [15:0]          lfsr_state;
    state_e               state_q, state_d;
    logic [NUM_SLOTS-1:0] snap_q, snap_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [5:0]           card_q, card_d;
    logic                 empty_q, empty_d;
    logic [5:0]           hit_card_q, hit_card_d;
    logic                 hit_empty_q, hit_empty_d;

    // The link abort only cancels the draw; the LFSR keeps running so entropy is not reset.
    lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .state (lfsr_state)
    );

    // Next-state and output logic; the result is staged in hit_* and published with done
    // so card/empty stay stable between done pulses.
    always_comb begin
        state_d     = state_q;
        snap_d      = snap_q;
        idx_d       = idx_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        card_d      = card_q;
        empty_d     = empty_q;
        hit_card_d  = hit_card_q;
        hit_empty_d = hit_empty_q;

        if (interboard_rst) begin
            state_d     = IDLE;
            snap_d      = '0;
            idx_d       = '0;
            busy_d      = 1'b0;
            card_d      = CARD_EMPTY;
            empty_d     = 1'b0;
            hit_card_d  = CARD_EMPTY;
            hit_empty_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // done_q high means this is the done cycle, where req is ignored.
                    if (req && !done_q) begin
                        snap_d = available_card;
                        busy_d = 1'b1;
                        if (available_card == '0) begin
                            hit_card_d  = CARD_EMPTY;
                            hit_empty_d = 1'b1;
                            state_d     = DONE;
                        end else begin
                            idx_d       = start_index(lfsr_state);
                            hit_empty_d = 1'b0;
                            state_d     = SCAN;
                        end
                    end
                end
                SCAN: begin
                    if (snap_q[idx_q]) begin
                        hit_card_d = slot_to_card(idx_q);
                        state_d    = DONE;
                    end else if (idx_q == IDX_W'(NUM_SLOTS - 1)) begin
                        idx_d = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                DONE: begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    card_d  = hit_card_q;
                    empty_d = hit_empty_q;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            snap_q      <= '0;
            idx_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            card_q      <= CARD_EMPTY;
            empty_q     <= 1'b0;
            hit_card_q  <= CARD_EMPTY;
            hit_empty_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            snap_q      <= snap_d;
            idx_q       <= idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            card_q      <= card_d;
            empty_q     <= empty_d;
            hit_card_q  <= hit_card_d;
            hit_empty_q <= hit_empty_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign card  = card_q;
    assign empty = empty_q;

endmodule

// File: tb/tb_deck_draw_picker.sv
// Scoreboard bench for deck_draw_picker: stimulus pushes expected results, a monitor checks each done.
module tb_deck_draw_picker;

    logic         clk = 1'b0;
    logic         rst;
    logic         interboard_rst;
    logic         req;
    logic [105:0] available_card;
    logic         busy;
    logic         done;
    logic [5:0]   card;
    logic         empty;

    typedef struct {
        int card;
        int empty;
        int cyc;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic [15:0] m;

    always #5 clk = ~clk;

    deck_draw_picker #(.SEED(16'hACE1)) dut (
        .clk            (clk),
        .rst            (rst),
        .interboard_rst (interboard_rst),
        .req            (req),
        .available_card (available_card),
        .busy           (busy),
        .done           (done),
        .card           (card),
        .empty          (empty)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Reference LFSR, reset only by rst.
    always @(posedge clk or posedge rst) begin
        if (rst) m <= 16'hACE1;
        else     m <= {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
    end

    function automatic int ref_idx(input logic [15:0] v);
        int s;
        s = int'(v[6:0]);
        return (s >= 106) ? s - 106 : s;
    endfunction

    function automatic int ref_card(input int slot);
        return (slot < 54) ? slot : slot - 54;
    endfunction

    function automatic int misses(input int target, input int start);
        return (target - start + 106) % 106;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected no done (t=%0t)", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("card", int'(card), e.card);
                check("empty", int'(empty), e.empty);
                check("done_cycle", cyc, e.cyc);
                check("busy_at_done", int'(busy), 0);
            end
        end
    end

    // Issue one req at the coming edge; returns the edge index and modelled start slot.
    task automatic draw(input logic [105:0] av, output int c0, output int idx);
        available_card = av;
        req = 1'b1;
        idx = ref_idx(m);
        c0  = cyc + 1;
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic push(input int c, input int e, input int at);
        exp_t x;
        x.card  = c;
        x.empty = e;
        x.cyc   = at;
        sb.push_back(x);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got %0d pending expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    logic [105:0] v;
    int c0, idx, lows, n;
    logic found;

    initial begin
        rst = 1'b0;
        interboard_rst = 1'b0;
        req = 1'b0;
        available_card = '0;
        #1 rst = 1'b1;
        #12;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_card", int'(card), 54);
        check("rst_empty", int'(empty), 0);
        @(negedge clk);
        rst = 1'b0;

        // Full deck, twice at different times.
        repeat (3) @(negedge clk);
        draw('1, c0, idx);
        push(ref_card(idx), 0, c0 + 2);
        wait_idle("full1");
        repeat (7) @(negedge clk);
        draw('1, c0, idx);
        push(ref_card(idx), 0, c0 + 2);
        wait_idle("full2");

        // Only slot 105, started at slot 0: full wrap-around scan.
        found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            if (ref_idx(m) == 0) found = 1'b1;
            else @(negedge clk);
        end
        if (!found) begin
            total++;
            bad++;
            $display("FAIL start0_search: got no start slot 0 expected one within 3000 cycles");
        end else begin
            v = '0;
            v[105] = 1'b1;
            draw(v, c0, idx);
            push(51, 0, c0 + 107);
            lows = 0;
            while (cyc <= c0 + 106) begin
                if (busy !== 1'b1) lows++;
                @(negedge clk);
            end
            check("busy_scan_lows", lows, 0);
            wait_idle("slot105");
        end

        // Single joker at two different request timings.
        v = '0;
        v[53] = 1'b1;
        draw(v, c0, idx);
        push(53, 0, c0 + 2 + misses(53, idx));
        wait_idle("joker1");
        repeat (5) @(negedge clk);
        draw(v, c0, idx);
        push(53, 0, c0 + 2 + misses(53, idx));
        wait_idle("joker2");

        // Slot 54 is the second copy of card 0.
        v = '0;
        v[54] = 1'b1;
        draw(v, c0, idx);
        push(0, 0, c0 + 2 + misses(54, idx));
        wait_idle("slot54");

        // Empty deck.
        draw('0, c0, idx);
        push(54, 1, c0 + 1);
        wait_idle("empty");

        // Mid-scan req and map change are ignored; req during done is ignored.
        v = '0;
        v[10] = 1'b1;
        draw(v, c0, idx);
        push(10, 0, c0 + 2 + misses(10, idx));
        available_card = '0;
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        check("req_in_done_ignored_busy", int'(busy), 0);
        repeat (150) @(negedge clk);
        check("isolation_pending", sb.size(), 0);

        // Async reset mid-scan.
        v = '0;
        v[105] = 1'b1;
        draw(v, c0, idx);
        repeat (20) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", int'(busy), 0);
        check("arst_done", int'(done), 0);
        check("arst_card", int'(card), 54);
        check("arst_empty", int'(empty), 0);
        #1 rst = 1'b0;
        repeat (150) @(negedge clk);
        check("arst_busy_after", int'(busy), 0);

        // Link abort mid-scan: a normal draw first so card is not at its reset value.
        v = '0;
        v[53] = 1'b1;
        draw(v, c0, idx);
        push(53, 0, c0 + 2 + misses(53, idx));
        wait_idle("pre_ibr");
        v = '0;
        v[105] = 1'b1;
        draw(v, c0, idx);
        repeat (5) @(negedge clk);
        interboard_rst = 1'b1;
        #1;
        check("ibr_not_yet_busy", int'(busy), 1);
        @(negedge clk);
        interboard_rst = 1'b0;
        check("ibr_busy", int'(busy), 0);
        check("ibr_card", int'(card), 54);
        check("ibr_empty", int'(empty), 0);

        // Link abort wins over a simultaneous req.
        available_card = '1;
        req = 1'b1;
        interboard_rst = 1'b1;
        @(negedge clk);
        req = 1'b0;
        interboard_rst = 1'b0;
        check("ibr_priority_busy", int'(busy), 0);
        repeat (150) @(negedge clk);
        check("final_pending", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/deck_draw_picker.md
# deck_draw_picker

Randomly selects one physical card still in the deck when the local player draws. It sits directly upstream of the memory handler. GameControl pulses a request, the block scans the handler's `available_card` vector from a pseudo-random start slot, and it returns the drawn card id. GameControl forwards that id as `ctrl_card` with `ctrl_msg_type = DECK_DRAW`, and the same message goes over the interboard link.

## Interface

Parameters:
- `SEED`, default `16'hACE1`: LFSR reset value. A value of 0 is replaced by `16'h0001`.

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `interboard_rst`, in, 1: synchronous abort from the link. Same effect as `rst`, applied at the next edge.
- `req`, in, 1: single-cycle draw request from GameControl.
- `available_card`, in, 106: slot map from the memory handler. Bit i = 1 means slot i is undrawn.
- `busy`, out, 1: the block is between accepting `req` and asserting `done`.
- `done`, out, 1: single-cycle pulse; `card` and `empty` are valid while it is high.
- `card`, out, 6: drawn card id 0–53, or 54 when nothing was drawn.
- `empty`, out, 1: qualifies `done`; the deck had no available slot.

## Operation

Slot-to-card mapping:
- Slots 0–53 map to card = slot.
- Slots 54–105 map to card = slot − 54. These are the second copies of cards 0–51.
- Jokers 52 and 53 exist once each.

LFSR:
- 16-bit Fibonacci form, advances every cycle in every state.
- feedback = l[15]^l[13]^l[12]^l[10].
- next = {l[14:0], feedback}.
- Randomness comes from the human-dependent cycle at which `req` arrives.

Start index:
- s = lfsr[6:0].
- idx = s − 106 when s ≥ 106, otherwise s.
- Result is always in 0–105.

State machine, states IDLE, SCAN, DONE:
- **IDLE**, `req` = 1:
  - Snapshot `available_card` into a 106-bit register.
  - If the snapshot is all zero, go to DONE with `empty` = 1 and `card` = 54.
  - Otherwise load idx from the start-index rule, set `busy` = 1, go to SCAN.
- **SCAN**, each cycle tests snapshot[idx]:
  - Hit: register the mapped card, go to DONE.
  - Miss: idx becomes 0 if idx = 105, otherwise idx + 1.
  - A non-empty snapshot always hits within 106 tests, so no timeout is needed.
- **DONE**: `done` = 1 for exactly one cycle, `busy` = 0, then IDLE. `card` and `empty` hold their values until the next `done`.

Other rules:
- `req` outside IDLE (including the cycle of `done`) is ignored and not queued.
- Changes to `available_card` after the snapshot do not affect the scan in progress.

## Timing

- Reset values: `busy` 0, `done` 0, `card` 54, `empty` 0, state IDLE, idx 0, snapshot 0, LFSR = effective SEED.
- Normal draw: `req` sampled at edge T0. After k misses, `done` is high in the cycle following edge T0+2+k. Worst case is k = 105.
- Empty deck: `done` is high in the cycle following edge T0+1.
- `busy` rises at edge T0 and falls at the edge that raises `done`.
- `rst` asynchronously aborts any scan: outputs return to their reset values and no `done` is produced.
- `interboard_rst` does the same at the next edge and takes priority over a simultaneous `req`.

## Structure

- Shared package `card_pkg` holds:
  - `CARD_EMPTY` = 6'd54
  - `NUM_SLOTS` = 106
  - `NUM_KINDS` = 54
  - state enum IDLE/SCAN/DONE
  
  The memory handler should import the same constants.
- One sub-module, `lfsr16`, with ports clk, rst and `SEED`, output 16-bit state. It is free-running and reusable for shuffle or initial deal.
- Slot-to-card mapping is a small function in `card_pkg`.

## Test plan

1. **Full deck:**
   - SEED default, `available_card` all ones, `req` 3 cycles after reset deassert.
   - Expect `done` after the fixed 2-edge latency.
   - `card` = (start idx < 54 ? idx : idx − 54), checked against a reference LFSR model; `empty` = 0.
2. **Single slot 105:**
   - Only bit 105 set; force start idx 0 via chosen `req` timing.
   - Expect `card` = 51 after the 105-miss wrap-around scan; `busy` high for the whole scan.
3. **Single joker:**
   - Only bit 53 set.
   - Expect `card` = 53 for every `req` timing.
   - Also check the slot 54 ↔ card 0 boundary: only bit 54 set gives `card` = 0.
4. **Empty deck:**
   - All zeros, `req`.
   - Expect `done` 1 edge later with `empty` = 1, `card` = 54.
5. **Ignored request and snapshot isolation:**
   - Pulse `req` again mid-scan and clear the target bit mid-scan.
   - Expect exactly one `done`, with the card from the snapshot.
6. **Abort:**
   - Assert `rst` asynchronously mid-scan.
   - Expect outputs at reset values immediately and no `done`.
   - Repeat with `interboard_rst`; effect appears at the next edge.
